// File: rtl/replace_ctrl_if.sv
// rtl/replace_ctrl_if.sv - miss, replacer, writeback, refill and touch channels of the replacement controller
interface replace_ctrl_if #(
    parameter int SET_W     = 6,
    parameter int TAG_W     = 20,
    parameter int WAY_NUM   = 4,
    parameter int WAY_IDX_W = 2
);
    // miss request
    logic                 miss_valid;
    logic                 miss_ready;
    logic [SET_W-1:0]     miss_set;
    logic [TAG_W-1:0]     miss_tag;

    // replacer query and victim metadata
    logic [SET_W-1:0]     rpl_set;
    logic [WAY_IDX_W-1:0] rpl_way;
    logic [WAY_NUM-1:0]   meta_dirty;

    // writeback channel
    logic                 wb_req_valid;
    logic                 wb_req_ready;
    logic [SET_W-1:0]     wb_set;
    logic [WAY_IDX_W-1:0] wb_way;
    logic                 wb_done;

    // refill channel
    logic                 fill_req_valid;
    logic                 fill_req_ready;
    logic [SET_W-1:0]     fill_set;
    logic [TAG_W-1:0]     fill_tag;
    logic [WAY_IDX_W-1:0] fill_way;
    logic                 fill_done;

    // hit touch from the lookup pipeline
    logic                 hit_touch_valid;
    logic                 hit_touch_ready;
    logic [SET_W-1:0]     hit_touch_set;
    logic [WAY_IDX_W-1:0] hit_touch_way;

    // replacer access port
    logic                 acc_valid;
    logic [SET_W-1:0]     acc_set;
    logic [WAY_IDX_W-1:0] acc_way;

    // completion and status
    logic                 done_valid;
    logic [WAY_IDX_W-1:0] done_way;
    logic                 busy;

    modport slave (
        input  miss_valid, miss_set, miss_tag,
        input  rpl_way, meta_dirty,
        input  wb_req_ready, wb_done,
        input  fill_req_ready, fill_done,
        input  hit_touch_valid, hit_touch_set, hit_touch_way,
        output miss_ready, rpl_set,
        output wb_req_valid, wb_set, wb_way,
        output fill_req_valid, fill_set, fill_tag, fill_way,
        output hit_touch_ready,
        output acc_valid, acc_set, acc_way,
        output done_valid, done_way, busy
    );

    modport master (
        output miss_valid, miss_set, miss_tag,
        output rpl_way, meta_dirty,
        output wb_req_ready, wb_done,
        output fill_req_ready, fill_done,
        output hit_touch_valid, hit_touch_set, hit_touch_way,
        input  miss_ready, rpl_set,
        input  wb_req_valid, wb_set, wb_way,
        input  fill_req_valid, fill_set, fill_tag, fill_way,
        input  hit_touch_ready,
        input  acc_valid, acc_set, acc_way,
        input  done_valid, done_way, busy
    );
endinterface

// File: rtl/replace_ctrl.sv
// rtl/replace_ctrl.sv - cache miss replacement sequencer: victim select, writeback, refill, PLRU touch
module replace_ctrl #(
    parameter int SET_W     = 6,
    parameter int TAG_W     = 20,
    parameter int WAY_NUM   = 4,
    parameter int WAY_IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    replace_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEL       = 3'd1,
        CHK       = 3'd2,
        WB_REQ    = 3'd3,
        WB_WAIT   = 3'd4,
        FILL_REQ  = 3'd5,
        FILL_WAIT = 3'd6,
        TOUCH     = 3'd7
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [SET_W-1:0]     cap_set;
    logic [TAG_W-1:0]     cap_tag;
    logic [WAY_IDX_W-1:0] victim;

    logic [WAY_NUM-1:0]   dirty_vec;
    logic                 victim_dirty;
    logic                 miss_fire;

    // The dirty vector belongs to the set currently on rpl_set; it is only
    // consulted in CHK, when rpl_way is the replacer's answer for that set.
    assign dirty_vec    = bus.meta_dirty;
    assign victim_dirty = dirty_vec[bus.rpl_way];
    assign miss_fire    = (state == IDLE) && bus.miss_valid;

    // State register; reset abandons any miss in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Miss address captured on acceptance, victim captured from the replacer in CHK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_set <= '0;
            cap_tag <= '0;
            victim  <= '0;
        end else begin
            if (miss_fire) begin
                cap_set <= bus.miss_set;
                cap_tag <= bus.miss_tag;
            end
            if (state == CHK) begin
                victim <= bus.rpl_way;
            end
        end
    end

    // Next-state decode; completion strobes are only honoured in their wait states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.miss_valid)     state_nxt = SEL;
            SEL:                               state_nxt = CHK;
            CHK:       state_nxt = victim_dirty ? WB_REQ : FILL_REQ;
            WB_REQ:    if (bus.wb_req_ready)   state_nxt = WB_WAIT;
            WB_WAIT:   if (bus.wb_done)        state_nxt = FILL_REQ;
            FILL_REQ:  if (bus.fill_req_ready) state_nxt = FILL_WAIT;
            FILL_WAIT: if (bus.fill_done)      state_nxt = TOUCH;
            TOUCH:                             state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Output decode; the refill touch owns the replacer access port in TOUCH,
    // otherwise hit touches pass straight through.
    always_comb begin
        bus.miss_ready      = (state == IDLE);
        bus.busy            = (state != IDLE);
        bus.rpl_set         = (state == IDLE) ? bus.miss_set : cap_set;

        bus.wb_req_valid    = (state == WB_REQ);
        bus.wb_set          = cap_set;
        bus.wb_way          = victim;

        bus.fill_req_valid  = (state == FILL_REQ);
        bus.fill_set        = cap_set;
        bus.fill_tag        = cap_tag;
        bus.fill_way        = victim;

        bus.done_valid      = (state == TOUCH);
        bus.done_way        = victim;

        bus.hit_touch_ready = (state != TOUCH);

        if (state == TOUCH) begin
            bus.acc_valid = rst_n;
            bus.acc_set   = cap_set;
            bus.acc_way   = victim;
        end else begin
            bus.acc_valid = rst_n & bus.hit_touch_valid;
            bus.acc_set   = bus.hit_touch_set;
            bus.acc_way   = bus.hit_touch_way;
        end
    end

endmodule

// File: tb/tb_replace_ctrl.sv
// tb/tb_replace_ctrl.sv - scoreboard bench for replace_ctrl
module tb_replace_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    replace_ctrl_if bus ();

    replace_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       kind;
        logic [31:0] set;
        logic [31:0] tag;
        logic [31:0] way;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input string kind, input logic [31:0] s, input logic [31:0] t,
                        input logic [31:0] w, input int c);
        exp_t e;
        e.kind = kind; e.set = s; e.tag = t; e.way = w; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string kind, input logic [31:0] s, input logic [31:0] t,
                            input logic [31:0] w);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_%s: got unexpected event set=%0h tag=%0h way=%0h cyc=%0d expected none",
                     kind, s, t, w, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.set !== s || e.tag !== t || e.way !== w || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL sb_%s: got %s set=%0h tag=%0h way=%0h cyc=%0d expected %s set=%0h tag=%0h way=%0h cyc=%0d",
                         kind, kind, s, t, w, cyc, e.kind, e.set, e.tag, e.way, e.cyc);
            end
        end
    endtask

    // Monitor: every observed handshake / strobe is matched against the expected queue.
    always @(negedge clk) begin
        if (bus.wb_req_valid === 1'b1 && bus.wb_req_ready === 1'b1)
            sb_check("wb", 32'(bus.wb_set), 32'd0, 32'(bus.wb_way));
        if (bus.fill_req_valid === 1'b1 && bus.fill_req_ready === 1'b1)
            sb_check("fill", 32'(bus.fill_set), 32'(bus.fill_tag), 32'(bus.fill_way));
        if (bus.acc_valid === 1'b1)
            sb_check("acc", 32'(bus.acc_set), 32'd0, 32'(bus.acc_way));
        if (bus.done_valid === 1'b1)
            sb_check("done", 32'd0, 32'd0, 32'(bus.done_way));
    end

    task automatic run_miss(input logic [5:0] s, input logic [19:0] t, input logic [1:0] w,
                            input logic [3:0] d, input int wb_stall, input bit hit_in_touch,
                            input bit spur);
        // cycle T: IDLE, miss accepted
        bus.miss_valid = 1'b1;
        bus.miss_set   = s;
        bus.miss_tag   = t;
        bus.rpl_way    = w;
        bus.meta_dirty = d;
        if (spur) begin
            bus.wb_done   = 1'b1;
            bus.fill_done = 1'b1;
        end
        chk("miss_ready_idle", bus.miss_ready, 1);
        tick();
        // T+1: SEL
        bus.miss_valid = 1'b0;
        bus.miss_set   = '0;
        bus.miss_tag   = '0;
        chk("rpl_set_sel", bus.rpl_set, s);
        chk("busy_sel", bus.busy, 1);
        chk("miss_ready_sel", bus.miss_ready, 0);
        tick();
        // T+2: CHK
        tick();
        // T+3: WB_REQ or FILL_REQ
        bus.wb_done   = 1'b0;
        bus.fill_done = 1'b0;
        if (d[w]) begin
            bus.wb_req_ready = 1'b0;
            for (int i = 0; i < wb_stall; i++) begin
                chk("wb_stall_valid", bus.wb_req_valid, 1);
                chk("wb_stall_set", bus.wb_set, s);
                chk("wb_stall_way", bus.wb_way, w);
                tick();
            end
            bus.wb_req_ready = 1'b1;
            push("wb", s, 0, w, cyc);
            tick();
            chk("no_fill_before_wb_done", bus.fill_req_valid, 0);
            tick();
            chk("no_fill_before_wb_done", bus.fill_req_valid, 0);
            bus.wb_done = 1'b1;
            tick();
            bus.wb_done = 1'b0;
        end
        push("fill", s, t, w, cyc);
        tick();
        tick();
        tick();
        bus.fill_done = 1'b1;
        tick();
        // TOUCH
        bus.fill_done = 1'b0;
        push("acc", s, 0, w, cyc);
        push("done", 0, 0, w, cyc);
        if (hit_in_touch) begin
            bus.hit_touch_valid = 1'b1;
            bus.hit_touch_set   = 6'd7;
            bus.hit_touch_way   = 2'd1;
            chk("hit_ready_touch", bus.hit_touch_ready, 0);
        end
        tick();
        // back in IDLE
        chk("miss_ready_after", bus.miss_ready, 1);
        chk("busy_after", bus.busy, 0);
        if (hit_in_touch) begin
            chk("hit_ready_after", bus.hit_touch_ready, 1);
            push("acc", 7, 0, 1, cyc);
            tick();
            bus.hit_touch_valid = 1'b0;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.miss_valid      = 1'b0;
        bus.miss_set        = '0;
        bus.miss_tag        = '0;
        bus.rpl_way         = '0;
        bus.meta_dirty      = '0;
        bus.wb_req_ready    = 1'b1;
        bus.wb_done         = 1'b0;
        bus.fill_req_ready  = 1'b1;
        bus.fill_done       = 1'b0;
        bus.hit_touch_valid = 1'b0;
        bus.hit_touch_set   = '0;
        bus.hit_touch_way   = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_miss_ready", bus.miss_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wb_req_valid", bus.wb_req_valid, 0);
        chk("rst_fill_req_valid", bus.fill_req_valid, 0);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_acc_valid", bus.acc_valid, 0);
        tick();

        // clean miss
        run_miss(6'd5, 20'h00123, 2'd2, 4'b0000, 0, 1'b0, 1'b0);
        tick();

        // dirty miss, immediate writeback acceptance
        run_miss(6'd33, 20'hFEDCB, 2'd3, 4'b1000, 0, 1'b0, 1'b0);
        tick();

        // dirty miss with writeback stalled four cycles, hit touch during TOUCH
        run_miss(6'd9, 20'hABCDE, 2'd1, 4'b0010, 4, 1'b1, 1'b0);
        tick();

        // dirty bits on other ways only: still a clean miss
        run_miss(6'd63, 20'h00001, 2'd0, 4'b1110, 0, 1'b0, 1'b0);

        // hit touch in IDLE passes through
        bus.hit_touch_valid = 1'b1;
        bus.hit_touch_set   = 6'd12;
        bus.hit_touch_way   = 2'd3;
        chk("hit_ready_idle", bus.hit_touch_ready, 1);
        push("acc", 12, 0, 3, cyc);
        tick();
        bus.hit_touch_valid = 1'b0;

        // spurious completions in IDLE
        bus.wb_done   = 1'b1;
        bus.fill_done = 1'b1;
        tick();
        bus.wb_done   = 1'b0;
        bus.fill_done = 1'b0;
        chk("spur_idle_busy", bus.busy, 0);
        chk("spur_idle_wb", bus.wb_req_valid, 0);
        chk("spur_idle_fill", bus.fill_req_valid, 0);

        // spurious completions during IDLE/SEL/CHK of a clean miss
        run_miss(6'd17, 20'h0BEEF, 2'd2, 4'b0000, 0, 1'b0, 1'b1);
        tick();

        // reset while waiting for refill
        bus.miss_valid = 1'b1;
        bus.miss_set   = 6'd20;
        bus.miss_tag   = 20'h55555;
        bus.rpl_way    = 2'd0;
        bus.meta_dirty = 4'b0000;
        tick();
        bus.miss_valid = 1'b0;
        tick();
        tick();
        push("fill", 20, 20'h55555, 0, cyc);
        tick();
        chk("rst_fw_busy", bus.busy, 1);
        rst_n = 1'b0;
        bus.hit_touch_valid = 1'b1;
        bus.hit_touch_set   = 6'd3;
        bus.hit_touch_way   = 2'd2;
        chk("rst_acc_gated", bus.acc_valid, 0);
        tick();
        rst_n = 1'b1;
        bus.hit_touch_valid = 1'b0;
        bus.fill_done = 1'b1;
        chk("rst_fw_busy_after", bus.busy, 0);
        chk("rst_fw_miss_ready", bus.miss_ready, 1);
        tick();
        bus.fill_done = 1'b0;
        chk("rst_fw_busy_late", bus.busy, 0);
        chk("rst_fw_done", bus.done_valid, 0);
        tick();
        tick();
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
